// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - core-side store/load signals and memory-side drain port of the store buffer
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          memwrite;
  logic          store_byte;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          memread;
  logic          stall;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_sb;
  logic          mem_ack;
  logic          empty;
  logic [CW-1:0] count;

  modport slave (
    input  memwrite, store_byte, dataadr, writedata, memread, mem_ack,
    output stall, mem_req, mem_addr, mem_wdata, mem_sb, empty, count
  );

  modport master (
    output memwrite, store_byte, dataadr, writedata, memread, mem_ack,
    input  stall, mem_req, mem_addr, mem_wdata, mem_sb, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO draining core stores to data memory over req/ack
// Flags full-buffer stores and same-word load hazards through stall.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] sb_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, push, pop, ld_hazard;

  assign full = (count_q == FULL_CNT);
  assign push = bus.memwrite & ~full;
  assign pop  = (count_q != '0) & bus.mem_ack;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from the head is below count.
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.memread && ({1'b0, PW'(i) - rd_ptr_q} < count_q) &&
          (addr_q[i][AW-1:2] == bus.dataadr[AW-1:2]))
        ld_hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sb_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        addr_q[wr_ptr_q] <= bus.dataadr;
        data_q[wr_ptr_q] <= bus.writedata;
        sb_q[wr_ptr_q]   <= bus.store_byte;
      end
    end
  end

  assign bus.stall     = (bus.memwrite & full) | ld_hazard;
  assign bus.mem_req   = (count_q != '0);
  assign bus.mem_addr  = addr_q[rd_ptr_q];
  assign bus.mem_wdata = data_q[rd_ptr_q];
  assign bus.mem_sb    = sb_q[rd_ptr_q];
  assign bus.empty     = (count_q == '0);
  assign bus.count     = count_q;
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - vector table, directed corner sequences and randomized queue-model check of store_buffer
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bif ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          sb;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic          mw;
    logic          sb;
    logic [AW-1:0] adr;
    logic [DW-1:0] wd;
    logic          mr;
    logic          ack;
    logic          e_stall;
    logic          e_req;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_sb;
    logic [2:0]    e_cnt;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0h expected %0h", phase, name, act, exp);
    end
  endtask

  function automatic logic model_hazard(input logic [AW-1:0] adr);
    foreach (mq[k]) if (mq[k].a[AW-1:2] == adr[AW-1:2]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic mw, input logic sb, input logic [AW-1:0] adr,
                       input logic [DW-1:0] wd, input logic mr, input logic ack);
    bif.memwrite   = mw;
    bif.store_byte = sb;
    bif.dataadr    = adr;
    bif.writedata  = wd;
    bif.memread    = mr;
    bif.mem_ack    = ack;
  endtask

  // One clock: compare outputs against the queue model, then advance the model.
  task automatic step(input logic rst, input logic mw, input logic sb, input logic [AW-1:0] adr,
                      input logic [DW-1:0] wd, input logic mr, input logic ack);
    bit   do_push, do_pop;
    ent_t e;
    reset = rst;
    drive(mw, sb, adr, wd, mr, ack);
    #1;
    check("stall", bif.stall, (mw && mq.size() == DEPTH) || (mr && model_hazard(adr)));
    check("mem_req", bif.mem_req, mq.size() != 0);
    check("empty", bif.empty, mq.size() == 0);
    check("count", bif.count, mq.size());
    if (mq.size() != 0) begin
      check("mem_addr", bif.mem_addr, mq[0].a);
      check("mem_wdata", bif.mem_wdata, mq[0].d);
      check("mem_sb", bif.mem_sb, mq[0].sb);
    end
    do_push = mw && (mq.size() < DEPTH);
    do_pop  = ack && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.a = adr; e.d = wd; e.sb = sb;
        mq.push_back(e);
      end
    end
    reset = 1'b0;
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
  endtask

  task automatic push_n(input int n, input logic [AW-1:0] base);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, 1'b0, base + AW'(4 * i), DW'(32'h100 + i), 1'b0, 1'b0);
  endtask

  task automatic idle_n(input int n, input logic ack);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, ack);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    check("count", bif.count, 0);
    check("empty", bif.empty, 1);
    check("mem_req", bif.mem_req, 0);
    check("mem_addr", bif.mem_addr, 0);
    check("mem_wdata", bif.mem_wdata, 0);
    check("mem_sb", bif.mem_sb, 0);
    check("stall", bif.stall, 0);
    reset = 1'b0;

    // mw sb adr wd mr ack | stall req addr data sb cnt
    vecs[0] = '{1, 0, 32'h54, 32'h7,  0, 1, 0, 0, 32'h0,  32'h0,  0, 3'd0};
    vecs[1] = '{0, 0, 32'h0,  32'h0,  0, 1, 0, 1, 32'h54, 32'h7,  0, 3'd1};
    vecs[2] = '{1, 1, 32'h51, 32'hAB, 0, 0, 0, 0, 32'h0,  32'h0,  0, 3'd0};
    vecs[3] = '{0, 0, 32'h50, 32'h0,  1, 0, 1, 1, 32'h51, 32'hAB, 1, 3'd1};
    vecs[4] = '{0, 0, 32'h54, 32'h0,  1, 0, 0, 1, 32'h51, 32'hAB, 1, 3'd1};
    vecs[5] = '{0, 0, 32'h53, 32'h0,  1, 1, 1, 1, 32'h51, 32'hAB, 1, 3'd1};
    vecs[6] = '{0, 0, 32'h50, 32'h0,  1, 0, 0, 0, 32'h0,  32'h0,  0, 3'd0};
    vecs[7] = '{1, 0, 32'h50, 32'h5,  1, 0, 0, 0, 32'h0,  32'h0,  0, 3'd0};
    vecs[8] = '{0, 0, 32'h52, 32'h0,  1, 1, 1, 1, 32'h50, 32'h5,  0, 3'd1};
    vecs[9] = '{0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  32'h0,  0, 3'd0};

    phase = "table";
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].mw, vecs[v].sb, vecs[v].adr, vecs[v].wd, vecs[v].mr, vecs[v].ack);
      #1;
      check($sformatf("v%0d_stall", v), bif.stall, vecs[v].e_stall);
      check($sformatf("v%0d_req", v), bif.mem_req, vecs[v].e_req);
      check($sformatf("v%0d_count", v), bif.count, vecs[v].e_cnt);
      check($sformatf("v%0d_empty", v), bif.empty, vecs[v].e_cnt == 3'd0);
      if (vecs[v].e_req) begin
        check($sformatf("v%0d_addr", v), bif.mem_addr, vecs[v].e_addr);
        check($sformatf("v%0d_data", v), bif.mem_wdata, vecs[v].e_data);
        check($sformatf("v%0d_sb", v), bif.mem_sb, vecs[v].e_sb);
      end
      @(posedge clk);
      #1;
    end

    phase = "full";
    hard_reset();
    push_n(4, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h110, 1'b0, 1'b0);
    check("count_held", bif.count, 4);
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h110, 1'b0, 1'b1);
    check("count_pop_no_push", bif.count, 3);
    check("head_after_pop", bif.mem_addr, 32'h04);
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h110, 1'b0, 1'b1);
    check("count_push_pop", bif.count, 3);
    check("head_third", bif.mem_addr, 32'h08);
    idle_n(3, 1'b1);
    check("drained_empty", bif.empty, 1);

    phase = "hold";
    hard_reset();
    push_n(2, 32'h20);
    idle_n(3, 1'b0);
    check("count_stable", bif.count, 2);
    check("addr_stable", bif.mem_addr, 32'h20);
    idle_n(1, 1'b1);
    check("count_after_ack", bif.count, 1);
    check("head_second", bif.mem_addr, 32'h24);

    phase = "wrap";
    hard_reset();
    push_n(2, 32'h40);
    step(1'b0, 1'b1, 1'b1, 32'h48, 32'hCAFE, 1'b0, 1'b1);
    check("count_same", bif.count, 2);
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, i[0], 32'h80 + AW'(4 * i), $urandom, 1'b0, 1'b1);
    check("count_after_wrap", bif.count, 2);
    idle_n(3, 1'b1);

    phase = "midreset";
    hard_reset();
    push_n(3, 32'h60);
    check("count_three", bif.count, 3);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    check("count_cleared", bif.count, 0);
    check("req_cleared", bif.mem_req, 0);
    check("empty_set", bif.empty, 1);
    idle_n(3, 1'b1);

    phase = "random";
    hard_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
           AW'($urandom_range(0, 31)), $urandom, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
Posted-write FIFO between the single-cycle core's data port and a handshaked data memory. Captures core stores (word or byte) in one cycle and drains them in order to memory over a req/ack interface. Flags full-buffer stores and read-after-write hazards so the core can stall. Sits directly downstream of the core's memwrite/dataadr/writedata/store_byte outputs and upstream of the data memory.

Parameters:
DEPTH, 4, number of buffered stores; power of 2, >= 2
AW, 32, address width in bits
DW, 32, data width in bits

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
memwrite  in  1  core store request this cycle
store_byte  in  1  store is a byte store (sb), else word store
dataadr  in  AW  core store/load byte address
writedata  in  DW  core store data (byte stores use bits [7:0])
memread  in  1  core load in progress this cycle, address on dataadr
stall  out  1  core must hold its current instruction this cycle
mem_req  out  1  head entry presented to memory
mem_addr  out  AW  head entry address
mem_wdata  out  DW  head entry data
mem_sb  out  1  head entry store_byte flag
mem_ack  in  1  memory accepts head entry this cycle
empty  out  1  no entries pending
count  out  $clog2(DEPTH)+1  number of pending entries

Behaviour:
- Reset (synchronous, active-high): count=0, read/write pointers=0, all entry storage cleared to 0. After reset: mem_req=0, empty=1, mem_addr=0, mem_wdata=0, mem_sb=0. stall=0 unless memwrite/memread stimulus is present.
- Reset asserted mid-operation discards all pending entries. No memory write completes for them after the reset edge, even if mem_ack is high in that cycle.
- Push: on a clock edge with memwrite=1 and count<DEPTH, store {dataadr, writedata, store_byte} at the write pointer and advance the pointer mod DEPTH. Contents are stored unmodified; byte merge happens in memory.
- Full: memwrite=1 with count==DEPTH -> no push and stall=1, even if a pop occurs the same cycle. The core retries next cycle.
- Pop/drain: mem_req = (count>0). mem_addr/mem_wdata/mem_sb show the head entry and stay stable while mem_req=1 and mem_ack=0. On an edge with mem_req=1 and mem_ack=1, advance the read pointer mod DEPTH. mem_ack is ignored when mem_req=0.
- Ordering: strictly FIFO. Entries drain in the order they were pushed.
- Simultaneous push and pop (count>0, count<DEPTH): both take effect and count is unchanged.
- Push into an empty buffer: mem_req rises the cycle after the push edge (registered count). Minimum store-to-memory latency is 1 cycle.
- Load hazard: ld_hazard (internal, combinational) = memread=1 and some valid entry has addr[AW-1:2]==dataadr[AW-1:2]. The byte offset is ignored.
- stall = (memwrite & count==DEPTH) | ld_hazard. It is purely combinational from the current inputs and registered state.
- empty = (count==0). It is used by halt/fence logic.
- Pointers wrap mod DEPTH. Full and empty are distinguished by count, never by pointer equality alone.
- Store data width: byte stores keep the full writedata in the entry. Only [7:0] is meaningful downstream.

Test Plan:
1. Reset, then push a word store addr 0x54, data 0x00000007, mem_ack=1 -> next cycle mem_req=1 with addr 0x54, data 7, sb=0; the cycle after, empty=1 and count=0.
2. mem_ack=0, push 4 stores to 0x00/0x04/0x08/0x0C, then a 5th store to 0x10 -> count=4 and stall=1 for the 5th store. Raise mem_ack -> entries drain in order 0x00,0x04,0x08,0x0C. The 0x10 store pushes on the first cycle count<4.
3. Hold mem_ack=0 for 3 cycles with count=2 -> mem_addr/mem_wdata/mem_sb are stable and count stays 2. Then one mem_ack pulse -> count=1 and the head is the second entry.
4. Pending sb to 0x51, then memread to 0x50 -> stall=1 (same word). memread to 0x54 -> stall=0. After the 0x51 entry drains, memread to 0x50 -> stall=0.
5. count=2 with mem_ack=1 and memwrite=1 in the same cycle -> count stays 2 and the new entry lands at the wrapped pointer. Run 10 push/pop cycles to confirm pointer wrap and FIFO order.
6. count=3, assert reset for 1 cycle with mem_ack=1 -> count=0, mem_req=0, empty=1, and no further mem_req until a new push.
